fifo_sync_vr: RTL and testbench
===============================

Name: fifo_sync_vr

Overview:
- Small synchronous first-word-fall-through FIFO with valid/ready on both sides.
- Sits directly downstream of the round-robin arbiters.
- Absorbs the arbiter's out_valid/out_data stream so a stalled consumer does not immediately back-pressure every arbitrated source.
- Decouples ready timing: in_ready depends only on registered state, never combinationally on out_ready.

Parameters:
- DWIDTH, 16, data width in bits; matches the arbiter DWIDTH.
- DEPTH, 4, number of entries; power of two, ≥2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low (asserted when 0).
- in_valid  in  1  upstream word valid; driven by arbiter out_valid.
- in_data  in  DWIDTH  upstream word.
- in_ready  out  1  FIFO accepts a word this cycle.
- out_valid  out  1  head word valid.
- out_data  out  DWIDTH  head word.
- out_ready  in  1  downstream consumes head this cycle.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.

Behaviour:
- Reset (rst=0, async, immediate effect): wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, out_valid=0. in_ready is forced 0 while rst=0 and is 1 from the first cycle after release. Storage array is not reset.
- Push = in_valid && in_ready. Writes mem[wr_ptr]; wr_ptr advances modulo DEPTH (width $clog2(DEPTH), natural wrap).
- Pop = out_valid && out_ready. rd_ptr advances modulo DEPTH.
- in_ready = !full. This is registered state only; no combinational path from out_ready.
- out_valid = !empty.
- out_data = mem[rd_ptr]. Value is don't-care when empty, and the bench must not check it.
- count update on each edge:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged
  - neither: unchanged
- full and empty are derived from registered count; there is no separate pointer-compare flag.
- Latency: a word pushed at edge N is visible on out_valid/out_data in the cycle after edge N (1 cycle). See the optional feature for the exception.
- Full with out_ready=1 and in_valid=1: pop only, no push, because in_ready=0. count drops to DEPTH−1; the upstream word is held by the arbiter (valid/ready contract) and accepted next cycle.
- Empty with out_ready=1: no pop; rd_ptr and count unchanged.
- Ordering: strict FIFO, no drop, no duplicate, across any number of pointer wraps.
- Reset asserted mid-operation: all buffered words are discarded. out_valid falls immediately (async). No pop is recorded.
- Upstream contract: in_data is stable while in_valid=1 && in_ready=0. The FIFO does not check this.

Optional Feature:
- Macro: FIFO_BYPASS_EN
- When defined: if empty=1 and in_valid=1, then out_valid=1 and out_data=in_data combinationally.
  - If out_ready=1 the word is transferred in the same cycle (0 latency). Nothing is written, and pointers and count are unchanged.
  - If out_ready=0 the word is pushed normally (count→1).
  - in_ready is still !full.
- When not defined: out_valid=!empty strictly, 1-cycle minimum latency, and no combinational in→out path.

Test Plan:
- Fill/drain: DEPTH=4, out_ready=0, push 0xA0,0xA1,0xA2,0xA3 → full=1, in_ready=0, count=4. Then out_ready=1 for 4 cycles → out_data sequence A0..A3, then empty=1, count=0.
- Concurrent push/pop: at count=2, in_valid=1 and out_ready=1 for 5 cycles with data 0x10..0x14 → count stays 2 every cycle; outputs are the 2 prior words then 0x10,0x11,0x12 in order.
- Full plus ready: count=4, in_valid=1 (0x55), out_ready=1 → that cycle in_ready=0 and head popped; next cycle count=3, in_ready=1, 0x55 accepted.
- Wrap: stream 11 words 0x00..0x0A with out_ready toggling every other cycle → all 11 received in order, no loss; pointers wrap at least twice.
- Reset mid-op: count=3, drive rst=0 between edges → out_valid=0 and empty=1 before the next edge. After release: count=0, in_ready=1, and the first new push 0x77 is the next word out.
- Bypass (FIFO_BYPASS_EN): empty, in_valid=1 with 0x3C, out_ready=1 → out_valid=1 and out_data=0x3C in the same cycle, count stays 0. Without the macro: out_valid=1 with 0x3C one cycle later.

Source files
------------

// File: rtl/fifo_sync_vr_if.sv
// ============================================================================
// Module  : fifo_sync_vr_if
// Brief   : Valid/ready stream bundle used on both sides of fifo_sync_vr.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface fifo_sync_vr_if #(
    parameter int DWIDTH = 16
);
    logic              valid;
    logic [DWIDTH-1:0] data;
    logic              ready;

    modport master (output valid, output data, input  ready);
    modport slave  (input  valid, input  data, output ready);
endinterface

`default_nettype wire

// File: rtl/fifo_sync_vr.sv
// ============================================================================
// Module  : fifo_sync_vr
// Brief   : First-word-fall-through synchronous FIFO with valid/ready on both
//           sides. Optional FIFO_BYPASS_EN gives a 0-latency path when empty.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_sync_vr #(
    parameter int DWIDTH = 16,
    parameter int DEPTH  = 4
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    fifo_sync_vr_if.slave               in_if,
    fifo_sync_vr_if.master              out_if,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        full,
    output logic                        empty
);
    localparam int                c_AW   = $clog2(DEPTH);
    localparam int                c_CW   = c_AW + 1;
    localparam logic [c_CW-1:0]   c_FULL = c_CW'(DEPTH);

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [c_AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [c_AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [c_CW-1:0]   count_q, count_d;
    logic              in_ready_q, in_ready_d;
    logic              w_empty;
    logic              w_bypass;
    logic              w_push;
    logic              w_pop;

    assign w_empty = (count_q == '0);

    always_comb begin
`ifdef FIFO_BYPASS_EN
        // An empty FIFO hands the upstream word straight through when taken now.
        w_bypass      = w_empty && in_if.valid && out_if.ready;
        out_if.valid  = !w_empty || in_if.valid;
        out_if.data   = w_empty ? in_if.data : mem_q[rd_ptr_q];
`else
        w_bypass      = 1'b0;
        out_if.valid  = !w_empty;
        out_if.data   = mem_q[rd_ptr_q];
`endif
    end

    always_comb begin
        w_push   = in_if.valid && in_ready_q && !w_bypass;
        w_pop    = !w_empty && out_if.ready;
        wr_ptr_d = w_push ? wr_ptr_q + c_AW'(1) : wr_ptr_q;
        rd_ptr_d = w_pop  ? rd_ptr_q + c_AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + c_CW'(1);
            2'b01:   count_d = count_q - c_CW'(1);
            default: count_d = count_q;
        endcase
        // Registered so in_ready never sees out_ready combinationally.
        in_ready_d = (count_d != c_FULL);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= in_if.data;
        end
    end

    assign in_if.ready = in_ready_q;
    assign count       = count_q;
    assign full        = (count_q == c_FULL);
    assign empty       = w_empty;

endmodule

`default_nettype wire

// File: tb/tb_fifo_sync_vr.sv
// ============================================================================
// Module  : tb_fifo_sync_vr
// Brief   : Scoreboard bench for fifo_sync_vr (honours FIFO_BYPASS_EN).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_sync_vr;
    localparam int c_DW    = 16;
    localparam int c_DEPTH = 4;
`ifdef FIFO_BYPASS_EN
    localparam bit c_BYP = 1'b1;
`else
    localparam bit c_BYP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] count;
    logic       full;
    logic       empty;

    fifo_sync_vr_if #(.DWIDTH(c_DW)) in_if ();
    fifo_sync_vr_if #(.DWIDTH(c_DW)) out_if ();

    fifo_sync_vr #(.DWIDTH(c_DW), .DEPTH(c_DEPTH)) u_dut (
        .clk    (clk),
        .rst    (rst),
        .in_if  (in_if),
        .out_if (out_if),
        .count  (count),
        .full   (full),
        .empty  (empty)
    );

    always #5 clk = ~clk;

    logic [c_DW-1:0] sb[$];
    int n_checks = 0;
    int n_pass   = 0;
    int n_pops   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // One clock cycle: drive, check at negedge against the model, update model.
    task automatic step(input logic v, input logic [c_DW-1:0] d, input logic r, output logic acc);
        logic exp_rdy, exp_ov;
        int   sz;
        in_if.valid  = v;
        in_if.data   = d;
        out_if.ready = r;
        @(negedge clk);
        sz      = sb.size();
        exp_rdy = (sz < c_DEPTH);
        exp_ov  = (sz != 0) || (c_BYP && v);
        chk("in_ready",  {31'd0, in_if.ready},  {31'd0, exp_rdy});
        chk("out_valid", {31'd0, out_if.valid}, {31'd0, exp_ov});
        chk("count",     {29'd0, count},        32'(sz));
        chk("full",      {31'd0, full},         {31'd0, sz == c_DEPTH});
        chk("empty",     {31'd0, empty},        {31'd0, sz == 0});
        acc = v && exp_rdy;
        if (acc) sb.push_back(d);
        if (exp_ov && r) begin
            if (sb.size() == 0) begin
                chk("pop_without_data", 32'd1, 32'd0);
            end else begin
                chk("out_data", {16'd0, out_if.data}, {16'd0, sb.pop_front()});
                n_pops++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic acc;
        int   sent;
        int   pops0;

        rst          = 1'b0;
        in_if.valid  = 1'b0;
        in_if.data   = '0;
        out_if.ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",  {31'd0, in_if.ready},  32'd0);
        chk("rst_out_valid", {31'd0, out_if.valid}, 32'd0);
        chk("rst_count",     {29'd0, count},        32'd0);
        chk("rst_empty",     {31'd0, empty},        32'd1);
        chk("rst_full",      {31'd0, full},         32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Fill then drain
        for (int i = 0; i < 4; i++) step(1'b1, 16'hA0 + 16'(i), 1'b0, acc);
        step(1'b1, 16'hEE, 1'b0, acc);
        chk("fill_reject", {31'd0, acc}, 32'd0);
        for (int i = 0; i < 5; i++) step(1'b0, 16'h0, 1'b1, acc);

        // Concurrent push/pop at count 2
        step(1'b1, 16'h20, 1'b0, acc);
        step(1'b1, 16'h21, 1'b0, acc);
        for (int i = 0; i < 5; i++) step(1'b1, 16'h10 + 16'(i), 1'b1, acc);
        for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b1, acc);

        // Full plus ready: pop only, then held word accepted
        for (int i = 0; i < 4; i++) step(1'b1, 16'hB0 + 16'(i), 1'b0, acc);
        step(1'b1, 16'h55, 1'b1, acc);
        chk("full_ready_no_push", {31'd0, acc}, 32'd0);
        step(1'b1, 16'h55, 1'b0, acc);
        chk("held_word_accepted", {31'd0, acc}, 32'd1);
        for (int i = 0; i < 5; i++) step(1'b0, 16'h0, 1'b1, acc);

        // Wrap: 11 words with out_ready toggling
        sent  = 0;
        pops0 = n_pops;
        for (int c = 0; c < 200 && (sent < 11 || sb.size() != 0); c++) begin
            step(sent < 11, 16'(sent), c[0], acc);
            if (acc) sent++;
        end
        chk("wrap_sent", 32'(sent), 32'd11);
        chk("wrap_recv", 32'(n_pops - pops0), 32'd11);

        // Asynchronous reset mid-operation
        for (int i = 0; i < 3; i++) step(1'b1, 16'hC0 + 16'(i), 1'b0, acc);
        in_if.valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, out_if.valid}, 32'd0);
        chk("midrst_empty",     {31'd0, empty},        32'd1);
        chk("midrst_count",     {29'd0, count},        32'd0);
        chk("midrst_in_ready",  {31'd0, in_if.ready},  32'd0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        step(1'b1, 16'h77, 1'b0, acc);
        step(1'b0, 16'h0, 1'b1, acc);

        // Empty with word arriving and consumer ready
        step(1'b1, 16'h3C, 1'b1, acc);
        chk("byp_count_after", {29'd0, count}, c_BYP ? 32'd0 : 32'd1);
        step(1'b0, 16'h0, 1'b1, acc);
        step(1'b0, 16'h0, 1'b1, acc);

        chk("sb_left", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
